// File: rtl/rr_moore_arbiter.sv
// rr_moore_arbiter: N-channel round-robin arbiter with Moore grant outputs.
// Each grant is followed by one dead cycle for bus turnaround. If another
// channel is waiting, a grant is limited to MAX_HOLD cycles.
// Optional macro ARB_LOCK_EN adds the lock input. While the owner holds
// lock=1, its grant does not expire and its tenure counter is frozen.
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-channel level request, held until done
//   lock       (ARB_LOCK_EN only) suppress expiry while in GRANT
//   gnt        one-hot grant, all-zero when nobody owns
//   gnt_id     index of current owner, 0 when gnt_valid=0
//   gnt_valid  OR of gnt
//   expired    1-cycle pulse in a dead cycle caused by tenure expiry
module rr_moore_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned IDW      = $clog2(N)
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [N-1:0]   req,
`ifdef ARB_LOCK_EN
   input  logic           lock,
`endif
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           expired
);

   localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t         state, state_d;
   logic [IDW-1:0] owner, owner_d;
   logic [IDW-1:0] rr_ptr, rr_ptr_d;
   logic [HCW-1:0] hold_cnt, hold_cnt_d;
   logic           exp_flag, exp_flag_d;

   logic [IDW-1:0] winner;
   logic [IDW-1:0] owner_inc;
   logic [N-1:0]   own_mask;
   logic [N-1:0]   req_rot;
   logic [2*N-1:0] req_dbl;
   logic           any_req;
   logic           owner_req;
   logic           others;
   logic           lock_act;

`ifdef ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   assign own_mask  = N'(1) << owner;
   assign owner_req = |(req & own_mask);
   assign others    = |(req & ~own_mask);
   assign owner_inc = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);

   // Rotate req so that bit 0 is the channel at rr_ptr, then pick the first set bit.
   always_comb begin
      int unsigned sum;
      sum     = 0;
      req_dbl = {req, req} >> rr_ptr;
      req_rot = req_dbl[N-1:0];
      winner  = '0;
      any_req = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!any_req && ((req_rot >> i) & N'(1)) != '0) begin
            any_req = 1'b1;
            sum     = 32'(rr_ptr) + i;
            if (sum >= N) sum = sum - N;
            winner  = IDW'(sum);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state;
      owner_d    = owner;
      rr_ptr_d   = rr_ptr;
      hold_cnt_d = hold_cnt;
      exp_flag_d = 1'b0;
      case (state)
         IDLE, RELEASE: begin
            if (any_req) begin
               state_d    = GRANT;
               owner_d    = winner;
               hold_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               state_d  = RELEASE;
               rr_ptr_d = owner_inc;
            end else if (!lock_act && others && hold_cnt >= HCW'(MAX_HOLD - 1)) begin
               // >= rather than ==: a saturated counter must still expire
               // as soon as a competitor shows up.
               state_d    = RELEASE;
               exp_flag_d = 1'b1;
               rr_ptr_d   = owner_inc;
            end else if (!lock_act && hold_cnt != HCW'(MAX_HOLD)) begin
               hold_cnt_d = hold_cnt + HCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         exp_flag <= 1'b0;
      end else begin
         state    <= state_d;
         owner    <= owner_d;
         rr_ptr   <= rr_ptr_d;
         hold_cnt <= hold_cnt_d;
         exp_flag <= exp_flag_d;
      end
   end

   // Registered Moore decode of the current state and owner.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         expired   <= 1'b0;
      end else begin
         gnt       <= (state == GRANT) ? own_mask : '0;
         gnt_id    <= (state == GRANT) ? owner : '0;
         gnt_valid <= (state == GRANT);
         expired   <= (state == RELEASE) && exp_flag;
      end
   end

endmodule

// File: tb/tb_rr_moore_arbiter.sv
// tb_rr_moore_arbiter: directed table plus corner-case sequences for rr_moore_arbiter (N=4, MAX_HOLD=8).
// Outputs are sampled on the falling edge. The outputs show the state from the
// previous rising edge, so a req sampled at edge k appears on gnt after edge k+1.
module tb_rr_moore_arbiter;

   logic       clock;
   logic       reset_n;
   logic [3:0] req;
   logic       lock;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       expired;

   int checks   = 0;
   int failures = 0;

   rr_moore_arbiter #(.N(4), .MAX_HOLD(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .expired   (expired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       valid;
      logic       expired;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                        input logic ev, input logic ee);
      checks++;
      if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || expired !== ee) begin
         failures++;
         $display("FAIL %s: got gnt=%b id=%0d valid=%b expired=%b, required gnt=%b id=%0d valid=%b expired=%b",
                  name, gnt, gnt_id, gnt_valid, expired, eg, eid, ev, ee);
      end
   endtask

   // Apply req for the next rising edge, then move to the falling edge for sampling.
   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [3:0] onehot(input int idx);
      logic [3:0] v;
      v = 4'b0001 << idx;
      return v;
   endfunction

   initial begin
      // Table: first grant, normal release, rr_ptr update, scan skipping channel 0.
      vecs[0]  = '{4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[5]  = '{4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[8]  = '{4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[9]  = '{4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[10] = '{4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[11] = '{4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[12] = '{4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[13] = '{4'b1001, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[14] = '{4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[15] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[16] = '{4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[17] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[18] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

      // Reset with every channel requesting: nothing may be granted.
      reset_n = 1'b0;
      req     = 4'b1111;
      lock    = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].req);
         check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].expired);
      end

      // Constant full request: expiry rotates the grant 0,1,2,3,0 with a dead cycle after each.
      step(4'b1111);
      check("full_first", 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 8; c++) begin
            step(4'b1111);
            check($sformatf("full_g%0d_c%0d", g, c), onehot(g % 4), 2'(g % 4), 1'b1, 1'b0);
         end
         step((g == 4) ? 4'b0000 : 4'b1111);
         check($sformatf("full_dead%0d", g), 4'b0000, 2'd0, 1'b0, 1'b1);
      end
      step(4'b0000);
      check("full_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // A lone requester never expires. A late competitor triggers expiry at once.
      step(4'b0010);
      check("solo_first", 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int c = 1; c < 20; c++) begin
         step(4'b0010);
         check($sformatf("solo_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      step(4'b0011);
      check("late_last", 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4'b0011);
      check("late_dead", 4'b0000, 2'd0, 1'b0, 1'b1);
      step(4'b0011);
      check("late_next", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Asynchronous reset between edges clears the grant immediately.
      #2 reset_n = 1'b0;
      #1 check("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      step(4'b0000);
      check("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_LOCK_EN
      // With lock held, owner 0 keeps the grant past MAX_HOLD until it drops req.
      lock = 1'b1;
      step(4'b1111);
      check("lock_first", 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         step(4'b1111);
         check($sformatf("lock_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      step(4'b1110);
      check("lock_last", 4'b0001, 2'd0, 1'b1, 1'b0);
      step(4'b1110);
      check("lock_dead", 4'b0000, 2'd0, 1'b0, 1'b0);
      step(4'b1110);
      check("lock_next", 4'b0010, 2'd1, 1'b1, 1'b0);
      lock = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
